// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the pipeline memory arbiter.
package mips_mem_pkg;

   // Arbiter control states, one transaction per pass through the loop.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Which requester owns the current transaction.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   // Cycles from the mem_en cycle to valid read data.
   localparam int MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // instruction-fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   // data-memory port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;
   // shared memory port
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter view.
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_done, d_rdata, d_done,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   // Environment view: pipeline stages plus the memory.
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_done, d_rdata, d_done,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// port that was not served last.
module arb_rr2
   import mips_mem_pkg::*;
(
   input  logic [1:0] req,          // bit 0 = IF, bit 1 = D
   input  owner_t     last_owner,
   output logic       grant_valid,
   output owner_t     grant
);

   // Combinational grant decode.
   always_comb begin
      // NOTE: every output gets a default before any branch so no latch is inferred.
      grant_valid = |req;
      grant       = OWN_IF;
      if (req == 2'b11) begin
         grant = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
      end else if (req[1]) begin
         grant = OWN_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF and D-stage accesses onto one fixed-latency memory port.
module mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus,
   output logic         busy
);

   localparam int              CNT_W   = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   owner_t            owner_q, owner_d;
   owner_t            last_owner_q, last_owner_d;
   logic              we_q, we_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_done_q, if_done_d;
   logic              d_done_q, d_done_d;

   logic [1:0] req_vec;
   logic       grant_valid;
   owner_t     grant;

   assign req_vec = {bus.d_req, bus.if_req};

   arb_rr2 u_arb (
      .req         (req_vec),
      .last_owner  (last_owner_q),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // Next-state and next-output decode; all outputs are registered below.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_done_d    = 1'b0;
      d_done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d      = ISSUE;
               owner_d      = grant;
               last_owner_d = grant;
               mem_en_d     = 1'b1;
               if (grant == OWN_D) begin
                  we_d        = bus.d_we;
                  mem_we_d    = bus.d_we;
                  mem_addr_d  = bus.d_addr;
                  mem_wdata_d = bus.d_wdata;
               end else begin
                  we_d       = 1'b0;
                  mem_addr_d = bus.if_addr;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
         end
         WAIT: begin
            if (cnt_q == LAT_CNT) begin
               state_d = DONE;
               cnt_d   = '0;
               if (owner_q == OWN_D) begin
                  d_done_d = 1'b1;
                  if (!we_q) d_rdata_d = bus.mem_rdata;
               end else begin
                  if_done_d  = 1'b1;
                  if_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         owner_q      <= OWN_IF;
         last_owner_q <= OWN_IF;
         we_q         <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_done_q    <= 1'b0;
         d_done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_done_q    <= if_done_d;
         d_done_q     <= d_done_d;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_done    = d_done_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default-latency instance plus a MEM_LAT=1 build.
module tb_mem_arbiter;

   logic clk;
   logic rst;
   logic busy;
   logic busy1;

   int checks;
   int errors;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus1.slave),
      .busy (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Contents of never-written locations.
   function automatic logic [31:0] rom(input logic [31:0] addr);
      case (addr)
         32'h40:  rom = 32'h8C090004;
         32'h44:  rom = 32'h12345678;
         32'h200: rom = 32'hCAFEF00D;
         default: rom = addr ^ 32'h5A5A5A5A;
      endcase
   endfunction

   // Memory model, latency 2: data appears two cycles after the mem_en cycle.
   logic [31:0] mem0 [0:255];
   bit          wr0  [0:255];
   logic [31:0] pipe0 [0:1];
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
         mem0[bus.mem_addr[9:2]] <= bus.mem_wdata;
         wr0[bus.mem_addr[9:2]]  <= 1'b1;
      end
      if (bus.mem_en && !bus.mem_we)
         pipe0[0] <= wr0[bus.mem_addr[9:2]] ? mem0[bus.mem_addr[9:2]] : rom(bus.mem_addr);
      else
         pipe0[0] <= 32'hx;
      pipe0[1] <= pipe0[0];
   end
   assign bus.mem_rdata = pipe0[1];

   // Memory model, latency 1 (read-only use).
   logic [31:0] pipe1;
   always @(posedge clk) begin
      pipe1 <= (bus1.mem_en && !bus1.mem_we) ? rom(bus1.mem_addr) : 32'hx;
   end
   assign bus1.mem_rdata = pipe1;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.if_req = 1'b0;  bus.if_addr = '0;
      bus.d_req = 1'b0;   bus.d_we = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
      bus1.if_req = 1'b0; bus1.if_addr = '0;
      bus1.d_req = 1'b0;  bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;

      // ---- reset state
      tick(2);
      check("rst_busy", busy, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_if_done", bus.if_done, 0);
      check("rst_d_done", bus.d_done, 0);
      check("rst_if_rdata", bus.if_rdata, 0);
      check("rst_d_rdata", bus.d_rdata, 0);
      rst = 1'b1;

      // ---- single fetch (cycle t = now)
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      tick();
      check("f_mem_en_t1", bus.mem_en, 1);
      check("f_mem_addr_t1", bus.mem_addr, 32'h40);
      check("f_mem_we_t1", bus.mem_we, 0);
      check("f_busy_t1", busy, 1);
      tick();
      check("f_mem_en_t2", bus.mem_en, 0);
      tick();
      check("f_if_done_t3", bus.if_done, 0);
      tick();
      check("f_if_done_t4", bus.if_done, 1);
      check("f_if_rdata_t4", bus.if_rdata, 32'h8C090004);
      check("f_d_done_t4", bus.d_done, 0);
      bus.if_req = 1'b0;
      tick();
      check("f_if_done_t5", bus.if_done, 0);
      check("f_busy_t5", busy, 0);

      // ---- D write then read
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
      tick();
      check("w_mem_en_t1", bus.mem_en, 1);
      check("w_mem_we_t1", bus.mem_we, 1);
      check("w_mem_addr_t1", bus.mem_addr, 32'h100);
      check("w_mem_wdata_t1", bus.mem_wdata, 32'hDEADBEEF);
      bus.d_wdata = 32'h0;    // must be ignored after latch
      tick(3);
      check("w_d_done_t4", bus.d_done, 1);
      check("w_d_rdata_kept", bus.d_rdata, 0);
      bus.d_req = 1'b0;
      tick();
      bus.d_req = 1'b1; bus.d_we = 1'b0;
      tick();
      check("r_mem_en_t1", bus.mem_en, 1);
      check("r_mem_we_t1", bus.mem_we, 0);
      tick(3);
      check("r_d_done_t4", bus.d_done, 1);
      check("r_d_rdata_t4", bus.d_rdata, 32'hDEADBEEF);
      check("r_if_rdata_hold", bus.if_rdata, 32'h8C090004);
      bus.d_req = 1'b0;
      tick();

      // ---- tie from reset: D, IF, D
      rst = 1'b0;
      tick();
      check("rr_rst_if_rdata", bus.if_rdata, 0);
      check("rr_rst_d_rdata", bus.d_rdata, 0);
      rst = 1'b1;
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
      tick();
      check("rr1_mem_en", bus.mem_en, 1);
      check("rr1_mem_addr", bus.mem_addr, 32'h200);
      tick(3);
      check("rr1_d_done", bus.d_done, 1);
      check("rr1_if_done", bus.if_done, 0);
      check("rr1_d_rdata", bus.d_rdata, 32'hCAFEF00D);
      tick();
      check("rr_gap_mem_en", bus.mem_en, 0);
      tick();
      check("rr2_mem_en", bus.mem_en, 1);
      check("rr2_mem_addr", bus.mem_addr, 32'h40);
      tick(3);
      check("rr2_if_done", bus.if_done, 1);
      check("rr2_d_done", bus.d_done, 0);
      check("rr2_if_rdata", bus.if_rdata, 32'h8C090004);
      tick(2);
      check("rr3_mem_en", bus.mem_en, 1);
      check("rr3_mem_addr", bus.mem_addr, 32'h200);
      bus.if_req = 1'b0; bus.d_req = 1'b0;   // dropped mid-transaction
      tick(3);
      check("rr3_d_done", bus.d_done, 1);
      tick();

      // ---- late arrival of D during an IF WAIT
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      tick();
      check("la_if_mem_en", bus.mem_en, 1);
      tick();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
      check("la_t2_mem_en", bus.mem_en, 0);
      tick();
      check("la_t3_mem_en", bus.mem_en, 0);
      tick();
      check("la_if_done", bus.if_done, 1);
      check("la_t4_mem_en", bus.mem_en, 0);
      check("la_t4_d_done", bus.d_done, 0);
      bus.if_req = 1'b0;
      tick();
      check("la_t5_mem_en", bus.mem_en, 0);
      tick();
      check("la_d_mem_en", bus.mem_en, 1);
      check("la_d_mem_addr", bus.mem_addr, 32'h100);
      tick(3);
      check("la_d_done", bus.d_done, 1);
      check("la_d_rdata", bus.d_rdata, 32'hDEADBEEF);
      bus.d_req = 1'b0;
      tick();

      // ---- reset mid-WAIT
      bus.if_req = 1'b1; bus.if_addr = 32'h44;
      tick();
      check("rw_mem_en", bus.mem_en, 1);
      tick();
      check("rw_busy_wait", busy, 1);
      rst = 1'b0;
      bus.if_req = 1'b0;
      #1;
      check("rw_busy_async", busy, 0);
      check("rw_mem_en_async", bus.mem_en, 0);
      check("rw_if_done_async", bus.if_done, 0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rw_no_done", bus.if_done, 0);
      end
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
      tick(4);
      check("rw_next_d_done", bus.d_done, 1);
      check("rw_next_d_rdata", bus.d_rdata, 32'hCAFEF00D);
      bus.d_req = 1'b0;
      tick();

      // ---- MEM_LAT = 1 build
      bus1.if_req = 1'b1; bus1.if_addr = 32'h44;
      tick();
      check("l1_mem_en", bus1.mem_en, 1);
      tick();
      check("l1_done_t2", bus1.if_done, 0);
      tick();
      check("l1_done_t3", bus1.if_done, 1);
      check("l1_rdata_t3", bus1.if_rdata, 32'h12345678);
      bus1.if_req = 1'b0;
      tick();
      check("l1_done_t4", bus1.if_done, 0);
      check("l1_busy_t4", busy1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
